mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter FIXED_PRIO, default 0, meaning 0 = round-robin, 1 = master 0 always wins ties.
REQ-002 Parameter TIMEOUT_CYCLES, default 64, meaning the slave response limit in cycles; used only under ARB_TIMEOUT_EN.
REQ-003 The block SHALL have exactly one clock, clk, and a synchronous active-low reset, resetn.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 resetn  in  1  synchronous reset, active low.
REQ-006 m0_valid/m0_instr  in  1/1  master 0 request and instruction-fetch flag.
REQ-007 m0_addr/m0_wdata/m0_wstrb  in  32/32/4  master 0 address, write data and byte strobes (strobes 0 = read).
REQ-008 m0_ready/m0_rdata  out  1/32  master 0 completion pulse and read data.
REQ-009 m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata SHALL mirror the m0_* ports for master 1.
REQ-010 s_valid/s_instr/s_addr/s_wdata/s_wstrb  out  1/1/32/32/4  shared memory request.
REQ-011 s_ready/s_rdata  in  1/32  memory completion and read data.
REQ-012 grant  out  2  one-hot owner of the slave port (bit0 = m0, bit1 = m1); 2'b00 when idle.
REQ-013 timeout_flag  out  1  sticky slave-timeout indicator.

Function
REQ-014 FSM states: IDLE, ACT0, ACT1.
REQ-015 In IDLE with exactly one mX_valid high, the next state SHALL be ACTX.
REQ-016 In IDLE with both valid: FIXED_PRIO=1 -> ACT0; FIXED_PRIO=0 -> the master not recorded in last_grant.
- last_grant is updated on entry to ACTx.
REQ-017 s_valid SHALL be registered: high exactly while in ACT0/ACT1, i.e. one cycle after the request is sampled in IDLE.
REQ-018 s_instr/s_addr/s_wdata/s_wstrb SHALL be driven from the granted master combinationally and SHALL be 0 in IDLE.
REQ-019 mX_ready SHALL equal s_ready AND state==ACTX (combinational); mX_rdata SHALL equal s_rdata when granted, else 0.
REQ-020 On s_ready in ACTx, the next state SHALL be IDLE.
- This guarantees s_valid is low for at least one cycle between transactions, resetting the slave's delay counter.
REQ-021 s_ready while in IDLE SHALL be ignored; no mX_ready is produced.
REQ-022 If the granted master drops mX_valid before s_ready, the transaction is aborted:
- next state IDLE, no mX_ready; a write may already have committed.
REQ-023 A non-granted master's request SHALL be held pending, with mX_ready low, until granted.
- There is no starvation: under round-robin, each master is served within two transactions.
REQ-024 grant SHALL be decoded from state and SHALL never be 2'b11.

Reset
REQ-025 With resetn low at a clk edge: state=IDLE, s_valid=0, grant=0, last_grant=1 (m0 wins the first tie), timeout counter=0, timeout_flag=0.
REQ-026 While in reset, all m*_ready outputs SHALL be 0.
REQ-027 A reset asserted mid-transaction SHALL drop s_valid on the next edge; no mX_ready is issued for the aborted transaction.

Configuration
REQ-028 Macro ARB_TIMEOUT_EN defined:
- a 16-bit counter clears on entry to ACTx and increments each ACTx cycle without s_ready;
- on reaching TIMEOUT_CYCLES-1, the arbiter pulses mX_ready with mX_rdata=32'hDEAD_BEEF, goes to IDLE, and sets timeout_flag;
- timeout_flag clears only on reset;
- s_ready in the same cycle as the limit wins: normal completion, no flag.
REQ-029 Macro ARB_TIMEOUT_EN undefined: no counter, timeout_flag tied to 0, ACTx waits for s_ready indefinitely.

Verification
REQ-030 Slave with 5-cycle latency; m0 reads 0x100 alone -> s_valid rises 1 cycle after m0_valid, s_addr=0x100, m0_ready coincides with s_ready, m0_rdata=s_rdata, then s_valid low for 1 or more cycles.
REQ-031 Both masters request continuously, FIXED_PRIO=0 -> grant sequence 01,10,01,10; each pair of grants is separated by an IDLE cycle.
REQ-032 Same stimulus, FIXED_PRIO=1 -> m0 granted every transaction; m1_ready stays 0 while m0_valid stays high.
REQ-033 m1 write 0xCAFEF00D, wstrb=4'b0011 to 0x1000_0000 -> s_wdata/s_wstrb match exactly, and m0 is blocked until m1_ready.
REQ-034 ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never ready -> m0_ready pulses on the 8th ACT0 cycle, m0_rdata=0xDEADBEEF, timeout_flag=1 until resetn low.
REQ-035 resetn driven low 2 cycles into ACT1 -> s_valid=0 and grant=0 on the next edge, and m1_ready is never asserted.

Source files
------------

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Two-master to one-slave memory arbiter. One transaction owns the slave
//   port at a time; the owner is chosen in IDLE, either round-robin or with
//   master 0 winning ties (FIXED_PRIO). Every transaction ends back in IDLE,
//   so s_valid is low for at least one cycle between transactions.
//
//   Optional feature: define ARB_TIMEOUT_EN to add a slave-response timeout.
//   A timed-out transaction completes to its master with 32'hDEAD_BEEF and
//   sets the sticky timeout_flag. Without the macro the arbiter waits for
//   s_ready indefinitely and timeout_flag is tied low.
//
// Ports
//   clk, resetn                 clock, synchronous active-low reset
//   m0_* / m1_*                 master request (valid, instr, addr, wdata,
//                               wstrb) and completion (ready, rdata)
//   s_valid .. s_wstrb          shared slave request (registered s_valid)
//   s_ready, s_rdata            slave completion and read data
//   grant                       one-hot owner, 2'b00 in IDLE
//   timeout_flag                sticky slave-timeout indicator
//
// State table
//   IDLE | no owner; pick a master from the pending requests
//   ACT0 | master 0 owns the slave port, waiting for completion
//   ACT1 | master 1 owns the slave port, waiting for completion
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int FIXED_PRIO     = 0,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        timeout_flag
);

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACT0 = 2'd1,
        ACT1 = 2'd2
    } state_t;

    state_t r_state;
    logic   r_s_valid;
    logic   r_last_grant;   // 0 = m0 granted last, 1 = m1 granted last
    logic   w_tmo;          // timeout fires this cycle
    logic   w_pick_m0;

    // Tie goes to m0 under fixed priority, or when m1 was served last.
    assign w_pick_m0 = m0_valid && (!m1_valid || (FIXED_PRIO != 0) || r_last_grant);

`ifdef ARB_TIMEOUT_EN
    logic [15:0] r_tmo_cnt;
    logic        r_tmo_flag;

    // s_ready arriving on the limit cycle wins over the timeout.
    assign w_tmo = (r_state != IDLE) && !s_ready &&
                   (r_tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

    // Counter is held at zero in IDLE, so it starts from zero on entry to ACTx.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_tmo_cnt  <= 16'd0;
            r_tmo_flag <= 1'b0;
        end else begin
            if (r_state == IDLE || w_tmo) begin
                r_tmo_cnt <= 16'd0;
            end else if (!s_ready) begin
                r_tmo_cnt <= r_tmo_cnt + 16'd1;
            end
            if (w_tmo) begin
                r_tmo_flag <= 1'b1;
            end
        end
    end

    assign timeout_flag = r_tmo_flag;
`else
    logic w_unused_tmo;

    assign w_tmo        = 1'b0;
    assign timeout_flag = 1'b0;
    assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_s_valid    <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_m0) begin
                        r_state      <= ACT0;
                        r_s_valid    <= 1'b1;
                        r_last_grant <= 1'b0;
                    end else if (m1_valid) begin
                        r_state      <= ACT1;
                        r_s_valid    <= 1'b1;
                        r_last_grant <= 1'b1;
                    end
                end
                ACT0: begin
                    // Completion, timeout, or abort by the owner all end here.
                    if (s_ready || w_tmo || !m0_valid) begin
                        r_state   <= IDLE;
                        r_s_valid <= 1'b0;
                    end
                end
                ACT1: begin
                    if (s_ready || w_tmo || !m1_valid) begin
                        r_state   <= IDLE;
                        r_s_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_s_valid <= 1'b0;
                end
            endcase
        end
    end

    assign s_valid = r_s_valid;
    assign grant   = {r_state == ACT1, r_state == ACT0};

    always_comb begin
        s_instr = 1'b0;
        s_addr  = 32'd0;
        s_wdata = 32'd0;
        s_wstrb = 4'd0;
        if (r_state == ACT0) begin
            s_instr = m0_instr;
            s_addr  = m0_addr;
            s_wdata = m0_wdata;
            s_wstrb = m0_wstrb;
        end else if (r_state == ACT1) begin
            s_instr = m1_instr;
            s_addr  = m1_addr;
            s_wdata = m1_wdata;
            s_wstrb = m1_wstrb;
        end
    end

    // resetn gating keeps ready low while reset is held, even if the
    // state register has not yet returned to IDLE.
    assign m0_ready = resetn && (r_state == ACT0) && (s_ready || w_tmo);
    assign m1_ready = resetn && (r_state == ACT1) && (s_ready || w_tmo);
    assign m0_rdata = (r_state == ACT0) ? (w_tmo ? TIMEOUT_RDATA : s_rdata) : 32'd0;
    assign m1_rdata = (r_state == ACT1) ? (w_tmo ? TIMEOUT_RDATA : s_rdata) : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter. Two instances run side by side: index 0 is
// round-robin, index 1 is fixed priority. Each has its own masters and its
// own slave responder.
module tb_mem_arbiter;

    localparam int          TMO       = 8;
    localparam logic [31:0] RD_KEY    = 32'hA5A5_0F0F;
    localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

    logic        clk;
    logic        resetn;
    logic        m0_valid [2];
    logic        m0_instr [2];
    logic [31:0] m0_addr  [2];
    logic [31:0] m0_wdata [2];
    logic [3:0]  m0_wstrb [2];
    logic        m0_ready [2];
    logic [31:0] m0_rdata [2];
    logic        m1_valid [2];
    logic        m1_instr [2];
    logic [31:0] m1_addr  [2];
    logic [31:0] m1_wdata [2];
    logic [3:0]  m1_wstrb [2];
    logic        m1_ready [2];
    logic [31:0] m1_rdata [2];
    logic        s_valid  [2];
    logic        s_instr  [2];
    logic [31:0] s_addr   [2];
    logic [31:0] s_wdata  [2];
    logic [3:0]  s_wstrb  [2];
    logic        s_ready  [2];
    logic [31:0] s_rdata  [2];
    logic [1:0]  grant    [2];
    logic        tflag    [2];

    logic        slv_rdy   [2];
    int          slv_cnt   [2];
    logic        force_rdy [2];
    int          slv_mode;   // 0 fixed latency, 1 random, 2 never ready
    int          slv_lat;

    int total;
    int bad;

    // reference model state
    int   own  [2];   // -1 idle, else owning master
    int   lastg[2];
    int   actc [2];
    logic mtf  [2];

    mem_arbiter #(.FIXED_PRIO(0), .TIMEOUT_CYCLES(TMO)) u_rr (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid[0]), .m0_instr(m0_instr[0]), .m0_addr(m0_addr[0]),
        .m0_wdata(m0_wdata[0]), .m0_wstrb(m0_wstrb[0]), .m0_ready(m0_ready[0]),
        .m0_rdata(m0_rdata[0]),
        .m1_valid(m1_valid[0]), .m1_instr(m1_instr[0]), .m1_addr(m1_addr[0]),
        .m1_wdata(m1_wdata[0]), .m1_wstrb(m1_wstrb[0]), .m1_ready(m1_ready[0]),
        .m1_rdata(m1_rdata[0]),
        .s_valid(s_valid[0]), .s_instr(s_instr[0]), .s_addr(s_addr[0]),
        .s_wdata(s_wdata[0]), .s_wstrb(s_wstrb[0]), .s_ready(s_ready[0]),
        .s_rdata(s_rdata[0]), .grant(grant[0]), .timeout_flag(tflag[0])
    );

    mem_arbiter #(.FIXED_PRIO(1), .TIMEOUT_CYCLES(TMO)) u_fp (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid[1]), .m0_instr(m0_instr[1]), .m0_addr(m0_addr[1]),
        .m0_wdata(m0_wdata[1]), .m0_wstrb(m0_wstrb[1]), .m0_ready(m0_ready[1]),
        .m0_rdata(m0_rdata[1]),
        .m1_valid(m1_valid[1]), .m1_instr(m1_instr[1]), .m1_addr(m1_addr[1]),
        .m1_wdata(m1_wdata[1]), .m1_wstrb(m1_wstrb[1]), .m1_ready(m1_ready[1]),
        .m1_rdata(m1_rdata[1]),
        .s_valid(s_valid[1]), .s_instr(s_instr[1]), .s_addr(s_addr[1]),
        .s_wdata(s_wdata[1]), .s_wstrb(s_wstrb[1]), .s_ready(s_ready[1]),
        .s_rdata(s_rdata[1]), .grant(grant[1]), .timeout_flag(tflag[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // slave responder: one-cycle s_ready pulse, read data derived from address
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!resetn || !s_valid[d] || slv_rdy[d]) begin
                slv_rdy[d] <= 1'b0;
                slv_cnt[d] <= 0;
            end else if (slv_mode == 0) begin
                if (slv_cnt[d] + 1 >= slv_lat) slv_rdy[d] <= 1'b1;
                else slv_cnt[d] <= slv_cnt[d] + 1;
            end else if (slv_mode == 1) begin
                slv_rdy[d] <= ($urandom_range(0, 2) == 0);
            end else begin
                slv_rdy[d] <= 1'b0;
            end
        end
    end

    assign s_ready[0] = slv_rdy[0] | force_rdy[0];
    assign s_ready[1] = slv_rdy[1] | force_rdy[1];
    assign s_rdata[0] = s_ready[0] ? (s_addr[0] ^ RD_KEY) : 32'd0;
    assign s_rdata[1] = s_ready[1] ? (s_addr[1] ^ RD_KEY) : 32'd0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        for (int d = 0; d < 2; d++) begin
            m0_valid[d] = 1'b0; m0_instr[d] = 1'b0; m0_addr[d] = '0; m0_wdata[d] = '0; m0_wstrb[d] = '0;
            m1_valid[d] = 1'b0; m1_instr[d] = 1'b0; m1_addr[d] = '0; m1_wdata[d] = '0; m1_wstrb[d] = '0;
            force_rdy[d] = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        set_idle();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        for (int d = 0; d < 2; d++) begin
            own[d] = -1; lastg[d] = 1; actc[d] = 0; mtf[d] = 1'b0;
        end
    endtask

    task automatic new_req(input int d, input int m);
        logic [31:0] a  = $urandom;
        logic [31:0] w  = $urandom;
        logic        i  = 1'($urandom_range(0, 1));
        logic [3:0]  st = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        if (m == 0) begin
            m0_valid[d] = 1'b1; m0_addr[d] = a; m0_wdata[d] = w; m0_instr[d] = i; m0_wstrb[d] = st;
        end else begin
            m1_valid[d] = 1'b1; m1_addr[d] = a; m1_wdata[d] = w; m1_instr[d] = i; m1_wstrb[d] = st;
        end
    endtask

    // ---- reset values, including ready gating while reset is held ----
    task automatic run_reset_checks();
        @(negedge clk);
        resetn = 1'b0;
        set_idle();
        m0_valid[0] = 1'b1; m1_valid[1] = 1'b1;
        force_rdy[0] = 1'b1; force_rdy[1] = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_s_valid[%0d]", d), 128'(s_valid[d]), 128'(0));
            chk($sformatf("rst_grant[%0d]", d), 128'(grant[d]), 128'(0));
            chk($sformatf("rst_tflag[%0d]", d), 128'(tflag[d]), 128'(0));
            chk($sformatf("rst_ready[%0d]", d), 128'({m0_ready[d], m1_ready[d]}), 128'(0));
            chk($sformatf("rst_s_addr[%0d]", d), 128'(s_addr[d]), 128'(0));
        end
        do_reset();
    endtask

    // ---- single-cycle grant decisions from IDLE, each then aborted ----
    typedef struct {
        logic       v0;
        logic       v1;
        logic [1:0] g_rr;
        logic [1:0] g_fp;
    } vec_t;

    task automatic run_table();
        vec_t tbl[10];
        logic [31:0] ea;
        tbl[0] = '{1'b1, 1'b1, 2'b01, 2'b01};
        tbl[1] = '{1'b1, 1'b1, 2'b10, 2'b01};
        tbl[2] = '{1'b0, 1'b1, 2'b10, 2'b10};
        tbl[3] = '{1'b1, 1'b1, 2'b01, 2'b01};
        tbl[4] = '{1'b1, 1'b0, 2'b01, 2'b01};
        tbl[5] = '{1'b1, 1'b1, 2'b10, 2'b01};
        tbl[6] = '{1'b0, 1'b0, 2'b00, 2'b00};
        tbl[7] = '{1'b0, 1'b1, 2'b10, 2'b10};
        tbl[8] = '{1'b1, 1'b0, 2'b01, 2'b01};
        tbl[9] = '{1'b1, 1'b1, 2'b10, 2'b01};
        do_reset();
        slv_mode = 0; slv_lat = 5;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                m0_valid[d] = tbl[i].v0; m0_addr[d] = 32'h1000 + 32'(i);
                m1_valid[d] = tbl[i].v1; m1_addr[d] = 32'h2000 + 32'(i);
            end
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_grant_rr", i), 128'(grant[0]), 128'(tbl[i].g_rr));
            chk($sformatf("tbl%0d_grant_fp", i), 128'(grant[1]), 128'(tbl[i].g_fp));
            chk($sformatf("tbl%0d_s_valid", i), 128'(s_valid[0]), 128'(tbl[i].g_rr != 2'b00));
            ea = (tbl[i].g_rr == 2'b01) ? 32'h1000 + 32'(i) :
                 (tbl[i].g_rr == 2'b10) ? 32'h2000 + 32'(i) : 32'h0;
            chk($sformatf("tbl%0d_s_addr", i), 128'(s_addr[0]), 128'(ea));
            chk($sformatf("tbl%0d_no_ready", i), 128'({m0_ready[0], m1_ready[0], m0_ready[1], m1_ready[1]}), 128'(0));
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                m0_valid[d] = 1'b0; m1_valid[d] = 1'b0;
            end
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_abort", i), 128'({grant[0], grant[1], s_valid[0], s_valid[1]}), 128'(0));
        end
    endtask

    // ---- lone read with 5-cycle slave ----
    task automatic run_latency();
        bit found = 0;
        do_reset();
        slv_mode = 0; slv_lat = 5;
        @(negedge clk);
        m0_valid[0] = 1'b1; m0_addr[0] = 32'h100; m0_wstrb[0] = 4'h0;
        #1 chk("lat_s_valid_before", 128'(s_valid[0]), 128'(0));
        @(posedge clk); #1;
        chk("lat_s_valid_rise", 128'(s_valid[0]), 128'(1));
        chk("lat_s_addr", 128'(s_addr[0]), 128'(32'h100));
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            chk("lat_ready_eq_sready", 128'(m0_ready[0]), 128'(s_ready[0]));
            if (s_ready[0]) begin
                found = 1;
                chk("lat_rdata", 128'(m0_rdata[0]), 128'(32'h100 ^ RD_KEY));
            end
        end
        chk("lat_completed", 128'(found), 128'(1));
        @(posedge clk); #1;
        m0_valid[0] = 1'b0;
        chk("lat_gap", 128'(s_valid[0]), 128'(0));
        @(posedge clk); #1;
        chk("lat_gap2", 128'(s_valid[0]), 128'(0));
    endtask

    // ---- both masters continuously requesting ----
    task automatic run_pair();
        logic [1:0] seq [2][4];
        int         n   [2];
        logic [1:0] pg  [2];
        logic       rp  [2];
        logic       m1_seen = 1'b0;
        do_reset();
        slv_mode = 0; slv_lat = 2;
        for (int d = 0; d < 2; d++) begin
            n[d] = 0; pg[d] = 2'b00; rp[d] = 1'b0;
            m0_valid[d] = 1'b1; m0_addr[d] = 32'hA0;
            m1_valid[d] = 1'b1; m1_addr[d] = 32'hB0;
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rp[d]) chk($sformatf("pair_gap[%0d]", d), 128'(grant[d]), 128'(0));
                if (grant[d] != 2'b00 && pg[d] == 2'b00 && n[d] < 4) begin
                    seq[d][n[d]] = grant[d];
                    n[d]++;
                end
                pg[d] = grant[d];
                rp[d] = m0_ready[d] | m1_ready[d];
            end
            m1_seen |= m1_ready[1];
        end
        chk("pair_count_rr", 128'(n[0]), 128'(4));
        chk("pair_count_fp", 128'(n[1]), 128'(4));
        chk("pair_seq_rr", 128'({seq[0][0], seq[0][1], seq[0][2], seq[0][3]}), 128'(8'b01_10_01_10));
        chk("pair_seq_fp", 128'({seq[1][0], seq[1][1], seq[1][2], seq[1][3]}), 128'(8'b01_01_01_01));
        chk("pair_fp_m1_ready", 128'(m1_seen), 128'(0));
        set_idle();
    endtask

    // ---- m1 write blocks a later m0 request ----
    task automatic run_write();
        bit done = 0;
        bit got0 = 0;
        do_reset();
        slv_mode = 0; slv_lat = 3;
        @(negedge clk);
        m1_valid[0] = 1'b1; m1_addr[0] = 32'h1000_0000; m1_wdata[0] = 32'hCAFE_F00D;
        m1_wstrb[0] = 4'b0011; m1_instr[0] = 1'b0;
        @(negedge clk);
        m0_valid[0] = 1'b1; m0_addr[0] = 32'h200; m0_wdata[0] = 32'h1234_5678; m0_wstrb[0] = 4'h0;
        #1;
        chk("wr_s_req", 128'({s_valid[0], s_instr[0], s_addr[0], s_wdata[0], s_wstrb[0]}),
            128'({1'b1, 1'b0, 32'h1000_0000, 32'hCAFE_F00D, 4'b0011}));
        for (int k = 0; k < 20 && !done; k++) begin
            chk("wr_m0_blocked", 128'({m0_ready[0], grant[0]}), 128'({1'b0, 2'b10}));
            if (m1_ready[0]) done = 1;
            else @(negedge clk);
        end
        chk("wr_m1_done", 128'(done), 128'(1));
        @(posedge clk); #1;
        m1_valid[0] = 1'b0;
        for (int k = 0; k < 5 && !got0; k++) begin
            @(negedge clk);
            if (grant[0] == 2'b01) got0 = 1;
        end
        chk("wr_m0_granted", 128'(got0), 128'(1));
        chk("wr_m0_addr", 128'(s_addr[0]), 128'(32'h200));
        set_idle();
    endtask

    // ---- reset two cycles into ACT1 ----
    task automatic run_midreset();
        do_reset();
        slv_mode = 2;
        @(negedge clk);
        m1_valid[0] = 1'b1; m1_addr[0] = 32'h300;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("mr_in_act1", 128'(grant[0]), 128'(2'b10));
        resetn = 1'b0;
        force_rdy[0] = 1'b1;
        #1 chk("mr_ready_gated", 128'(m1_ready[0]), 128'(0));
        @(posedge clk); #1;
        chk("mr_dropped", 128'({s_valid[0], grant[0], m1_ready[0]}), 128'(0));
        @(negedge clk);
        force_rdy[0] = 1'b0;
        m1_valid[0] = 1'b0;
        resetn = 1'b1;
    endtask

    // ---- slave never ready ----
    task automatic run_timeout();
        do_reset();
        slv_mode = 2;
        @(negedge clk);
        m0_valid[0] = 1'b1; m0_addr[0] = 32'h400;
`ifdef ARB_TIMEOUT_EN
        for (int k = 1; k <= TMO; k++) begin
            @(negedge clk);
            chk($sformatf("tmo_ready_c%0d", k), 128'(m0_ready[0]), 128'(k == TMO));
            if (k == TMO) chk("tmo_rdata", 128'(m0_rdata[0]), 128'(DEAD_BEEF));
        end
        @(posedge clk); #1;
        m0_valid[0] = 1'b0;
        chk("tmo_flag_set", 128'({tflag[0], grant[0]}), 128'({1'b1, 2'b00}));
        repeat (5) @(posedge clk);
        #1 chk("tmo_flag_sticky", 128'(tflag[0]), 128'(1));
        do_reset();
        @(posedge clk); #1;
        chk("tmo_flag_cleared", 128'(tflag[0]), 128'(0));
`else
        begin
            logic any = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                any |= m0_ready[0];
            end
            chk("notmo_no_ready", 128'(any), 128'(0));
            chk("notmo_still_act", 128'({grant[0], tflag[0]}), 128'({2'b01, 1'b0}));
        end
        set_idle();
`endif
    endtask

    // ---- random traffic against the reference model ----
    task automatic run_random(input int cycles);
        logic seen0 [2];
        logic seen1 [2];
        do_reset();
        slv_mode = 1;
        for (int d = 0; d < 2; d++) begin
            seen0[d] = 1'b0; seen1[d] = 1'b0;
        end
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (m0_valid[d]) begin
                    if (seen0[d]) begin
                        if ($urandom_range(0, 1) == 1) new_req(d, 0); else m0_valid[d] = 1'b0;
                    end else if ($urandom_range(0, 31) == 0) m0_valid[d] = 1'b0;
                end else if ($urandom_range(0, 1) == 1) new_req(d, 0);
                if (m1_valid[d]) begin
                    if (seen1[d]) begin
                        if ($urandom_range(0, 1) == 1) new_req(d, 1); else m1_valid[d] = 1'b0;
                    end else if ($urandom_range(0, 31) == 0) m1_valid[d] = 1'b0;
                end else if ($urandom_range(0, 1) == 1) new_req(d, 1);
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                int          o   = own[d];
                logic        tmo = 1'b0;
                logic        ei  = 1'b0;
                logic [31:0] ea  = '0;
                logic [31:0] ew  = '0;
                logic [3:0]  es  = '0;
                logic [31:0] rd;
                logic        r0, r1;
`ifdef ARB_TIMEOUT_EN
                tmo = (o >= 0) && (actc[d] == TMO - 1) && !s_ready[d];
`endif
                if (o == 0) begin
                    ei = m0_instr[d]; ea = m0_addr[d]; ew = m0_wdata[d]; es = m0_wstrb[d];
                end else if (o == 1) begin
                    ei = m1_instr[d]; ea = m1_addr[d]; ew = m1_wdata[d]; es = m1_wstrb[d];
                end
                rd = tmo ? DEAD_BEEF : (s_ready[d] ? (ea ^ RD_KEY) : 32'd0);
                r0 = (o == 0) && (s_ready[d] || tmo);
                r1 = (o == 1) && (s_ready[d] || tmo);
                chk($sformatf("rnd%0d_grant", d), 128'(grant[d]),
                    128'((o == 0) ? 2'b01 : (o == 1) ? 2'b10 : 2'b00));
                chk($sformatf("rnd%0d_sreq", d),
                    128'({s_valid[d], s_instr[d], s_addr[d], s_wdata[d], s_wstrb[d]}),
                    128'({o >= 0, ei, ea, ew, es}));
                chk($sformatf("rnd%0d_ready", d), 128'({m0_ready[d], m1_ready[d]}), 128'({r0, r1}));
                chk($sformatf("rnd%0d_rdata", d), 128'({m0_rdata[d], m1_rdata[d]}),
                    128'({(o == 0) ? rd : 32'd0, (o == 1) ? rd : 32'd0}));
                chk($sformatf("rnd%0d_tflag", d), 128'(tflag[d]), 128'(mtf[d]));
                seen0[d] = r0;
                seen1[d] = r1;
                // advance the model across the coming edge
                if (o < 0) begin
                    if (m0_valid[d] && m1_valid[d])
                        own[d] = (d == 1) ? 0 : ((lastg[d] == 1) ? 0 : 1);
                    else if (m0_valid[d]) own[d] = 0;
                    else if (m1_valid[d]) own[d] = 1;
                    if (own[d] >= 0) begin
                        lastg[d] = own[d];
                        actc[d]  = 0;
                    end
                end else if (s_ready[d] || tmo) begin
                    if (tmo) mtf[d] = 1'b1;
                    own[d] = -1;
                end else if ((o == 0 && !m0_valid[d]) || (o == 1 && !m1_valid[d])) begin
                    own[d] = -1;
                end else begin
                    actc[d]++;
                end
            end
        end
        set_idle();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        resetn = 1'b0;
        slv_mode = 0;
        slv_lat  = 5;
        set_idle();
        run_reset_checks();
        run_table();
        run_latency();
        run_pair();
        run_write();
        run_midreset();
        run_timeout();
        run_random(3000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

endmodule
